// File: rtl/dm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Stores to TXDATA fill a small FIFO; a serializer FSM drains it onto o_tx.
// Loads are combinational so a single-cycle core sees STATUS/CTRL at once.
module dm_uart_tx #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   BASE_ADDR    = XLEN'(32'h1000_0000),
  parameter int                CLKS_PER_BIT = 16,
  parameter int                FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic            i_dm_wvalid,
  input  logic [XLEN-1:0] i_dm_wdata,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_hit,
  output logic            o_tx,
  output logic            o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bus decode
  logic [1:0] offset;
  logic       wr_en;
  logic       push_req;
  logic       push_ok;
  logic       pop;

  assign o_hit    = (i_dm_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign offset   = i_dm_addr[3:2];
  assign wr_en    = o_hit & i_dm_wvalid;
  assign push_req = wr_en & (offset == OFF_TXDATA);

  // Byte-lane and sub-word address bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{i_dm_addr[1:0], i_dm_wdata[XLEN-1:8]};

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  // A full FIFO can still take a byte when the serializer frees a slot
  // on the same edge; the write lands in the slot being vacated.
  assign push_ok = push_req & (~full | pop);

  // FIFO pointers and occupancy
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage
  // NOTE: the data array has no reset; occupancy is tracked by the reset
  // pointers/count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_dm_wdata[7:0];
  end

  // Control and sticky overflow registers
  logic tx_en_q, irq_en_q, overflow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en && offset == OFF_CTRL) begin
        tx_en_q  <= i_dm_wdata[0];
        irq_en_q <= i_dm_wdata[1];
      end
      if (push_req && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (wr_en && offset == OFF_STATUS && i_dm_wdata[3]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Serializer state
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy;
  logic          can_pop;

  assign busy    = (state_q != ST_IDLE);
  assign can_pop = tx_en_q & ~empty;

  // Serializer next-state: frame sequencing, bit timing and FIFO pop
  // NOTE: every combinational output gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin // ST_STOP
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (can_pop) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Line level follows the state being entered so o_tx stays a clean flop.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
  end

  // Serializer registers; the line idles high out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign o_tx  = tx_q;
  assign o_irq = irq_en_q & empty & ~busy;

  // Load data mux; zero outside the window and for write-only/reserved slots
  always_comb begin
    o_dm_rdata = '0;
    if (o_hit) begin
      case (offset)
        OFF_STATUS: begin
          o_dm_rdata[0]    = full;
          o_dm_rdata[1]    = empty;
          o_dm_rdata[2]    = busy;
          o_dm_rdata[3]    = overflow_q;
          o_dm_rdata[15:8] = 8'(count_q);
        end
        OFF_CTRL: begin
          o_dm_rdata[0] = tx_en_q;
          o_dm_rdata[1] = irq_en_q;
        end
        default: o_dm_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_uart_tx.sv
// Testbench for dm_uart_tx: directed bus stimulus, serial-line scoreboard.
module tb_dm_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STS  = BASE + 32'h4;
  localparam logic [31:0] CTL  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr, wdata, rdata;
  logic        wvalid, hit, tx, irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_wr;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  dm_uart_tx #(
    .XLEN(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_dm_addr(addr), .i_dm_wvalid(wvalid), .i_dm_wdata(wdata),
    .o_dm_rdata(rdata), .o_hit(hit), .o_tx(tx), .o_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a;
    #1;
    check(n, rdata, e);
  endtask

  // Capture happens at the next rising edge; last_wr records its cycle index.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wvalid = 1'b1;
    @(posedge clk);
    #1;
    wvalid  = 1'b0;
    last_wr = cyc;
  endtask

  // Write captured exactly at rising edge number 'target'.
  task automatic bus_write_at(input int target, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (cyc >= target) begin
      check("write_at_reachable", 32'(cyc), 32'(target - 1));
    end else begin
      while (cyc != target - 1) @(negedge clk);
      addr = a; wdata = d; wvalid = 1'b1;
      @(posedge clk);
      #1;
      wvalid  = 1'b0;
      last_wr = cyc;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic txd(input logic [7:0] b, input bit expect_sent);
    bus_write(TXD, {24'h0, b});
    if (expect_sent) exp_q.push_back(b);
  endtask

  // Serial monitor: decodes frames at mid-bit and checks them against exp_q.
  initial begin
    bit         active = 1'b0;
    logic       prev   = 1'b1;
    int         off    = 0;
    logic [7:0] rx     = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        active = 1'b0;
        prev   = 1'b1;
      end else if (!active) begin
        if (prev && !tx) begin
          active = 1'b1;
          off    = 0;
          start_cyc.push_back(cyc);
        end
        prev = tx;
      end else begin
        off++;
        if (off == C / 2) begin
          check("rx_start_bit", 32'(tx), 32'd0);
        end else if (off >= C + C / 2 && off < 9 * C && (off - C - C / 2) % C == 0) begin
          rx[(off - C - C / 2) / C] = tx;
        end else if (off == 9 * C + C / 2) begin
          check("rx_stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got byte 0x%02h expected no frame", rx);
          end else begin
            check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
          active = 1'b0;
          prev   = 1'b1;
        end
      end
    end
  end

  initial begin
    int w, r, n, lows;
    addr = STS; wdata = '0; wvalid = 1'b0; rstn = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hit", 32'(hit), 32'd1);
    rd_chk(STS, 32'h0000_0002, "rst_status");
    rd_chk(CTL, 32'h0000_0000, "rst_ctrl");
    @(negedge clk);
    rstn = 1'b1;

    // Single frame 0xA5, line timing and busy duration
    bus_write(CTL, 32'h1);
    rd_chk(CTL, 32'h1, "ctrl_readback");
    start_cyc.delete();
    txd(8'hA5, 1'b1);
    w = last_wr;
    check("t1_tx_before", 32'(tx), 32'd1);
    rd_chk(STS, 32'h0000_0100, "t1_status_queued");
    @(posedge clk); #1;
    check("t1_tx_fall", 32'(tx), 32'd0);
    rd_chk(STS, 32'h0000_0006, "t1_status_busy");
    n = 0;
    for (int i = 0; i < 50; i++) begin
      addr = STS; #1;
      if (rdata[2]) n++;
      @(posedge clk); #1;
    end
    check("t1_busy_cycles", 32'(n), 32'd40);
    rd_chk(STS, 32'h0000_0002, "t1_status_after");
    check("t1_frames", 32'(start_cyc.size()), 32'd1);
    if (start_cyc.size() > 0) check("t1_start_cyc", 32'(start_cyc[0]), 32'(w + 1));

    // Overflow and back-to-back drain
    bus_write(CTL, 32'h0);
    for (int i = 1; i <= 9; i++) txd(8'(i), i <= 8);
    rd_chk(STS, 32'h0000_0809, "t2_status_ovf");
    bus_write(STS, 32'h8);
    rd_chk(STS, 32'h0000_0801, "t2_ovf_clear");
    start_cyc.delete();
    bus_write(CTL, 32'h1);
    w = last_wr;
    wait_cyc(w + 330);
    check("t2_frames", 32'(start_cyc.size()), 32'd8);
    if (start_cyc.size() == 8) begin
      check("t2_first_start", 32'(start_cyc[0]), 32'(w + 1));
      for (int i = 1; i < 8; i++)
        check("t2_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'(10 * C));
    end
    rd_chk(STS, 32'h0000_0002, "t2_status_after");

    // Push into a full FIFO on the pop cycle
    bus_write(CTL, 32'h0);
    for (int i = 0; i < 8; i++) txd(8'h10 + 8'(i), 1'b1);
    start_cyc.delete();
    bus_write(CTL, 32'h1);
    w = last_wr;
    txd(8'h18, 1'b1);
    rd_chk(STS, 32'h0000_0805, "t3_refilled");
    bus_write_at(w + 1 + 10 * C, TXD, 32'h55);
    exp_q.push_back(8'h55);
    rd_chk(STS, 32'h0000_0805, "t3_pop_push");
    wait_cyc(w + 1 + 100 * C + 10);
    check("t3_frames", 32'(start_cyc.size()), 32'd10);
    rd_chk(STS, 32'h0000_0002, "t3_status_after");

    // Clear tx_en mid-frame, then re-enable
    bus_write(CTL, 32'h0);
    txd(8'h3C, 1'b1);
    txd(8'hC3, 1'b1);
    start_cyc.delete();
    bus_write(CTL, 32'h1);
    w = last_wr;
    bus_write_at(w + 15, CTL, 32'h0);
    wait_cyc(w + 45);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("t4_line_idle", 32'(lows), 32'd0);
    rd_chk(STS, 32'h0000_0100, "t4_one_left");
    check("t4_frames_paused", 32'(start_cyc.size()), 32'd1);
    bus_write(CTL, 32'h1);
    r = last_wr;
    wait_cyc(r + 10 * C + 5);
    check("t4_frames_resumed", 32'(start_cyc.size()), 32'd2);
    if (start_cyc.size() == 2) check("t4_restart_cyc", 32'(start_cyc[1]), 32'(r + 1));

    // Interrupt behaviour and window decode
    bus_write(CTL, 32'h3);
    check("t5_irq_idle", 32'(irq), 32'd1);
    txd(8'h96, 1'b1);
    w = last_wr;
    check("t5_irq_queued", 32'(irq), 32'd0);
    wait_cyc(w + 20);
    check("t5_irq_busy", 32'(irq), 32'd0);
    wait_cyc(w + 10 * C);
    check("t5_irq_last_stop", 32'(irq), 32'd0);
    wait_cyc(w + 10 * C + 1);
    check("t5_irq_rise", 32'(irq), 32'd1);
    addr = BASE + 32'h20; #1;
    check("t5_miss_hit", 32'(hit), 32'd0);
    rd_chk(BASE + 32'h24, 32'h0, "t5_miss_rdata");
    start_cyc.delete();
    bus_write(BASE + 32'h20, 32'h77);
    repeat (10) @(posedge clk);
    #1;
    check("t5_miss_no_frame", 32'(start_cyc.size()), 32'd0);
    rd_chk(STS, 32'h0000_0002, "t5_miss_status");
    check("t5_hit", 32'(hit), 32'd1);

    // Reset during DATA bit 3
    bus_write(CTL, 32'h1);
    txd(8'hF0, 1'b0);
    w = last_wr;
    txd(8'hAB, 1'b0);
    wait_cyc(w + 19);
    check("t6_bit3_low", 32'(tx), 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_async_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    rd_chk(STS, 32'h0000_0002, "t6_status");
    rd_chk(CTL, 32'h0000_0000, "t6_ctrl");
    start_cyc.delete();
    bus_write(CTL, 32'h1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("t6_no_residual", 32'(lows), 32'd0);
    check("t6_no_frame", 32'(start_cyc.size()), 32'd0);
    rd_chk(STS, 32'h0000_0002, "t6_status_after");

    check("rx_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_uart_tx.md
Name: dm_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data memory bus, directly downstream of the core's data port (addr/wvalid/wdata out, rdata in).
- CPU stores push bytes into a TX FIFO. A serializer FSM drains the FIFO as 8N1 frames on a single output pin.
- Read data is combinational from registered state, so the single-cycle core can load STATUS/CTRL in the same cycle.

Parameters:
- XLEN, 32, bus data/address width
- BASE_ADDR, 32'h1000_0000, block base; decode uses addr[XLEN-1:4], 16-byte window
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- i_dm_addr  input  XLEN  data bus address
- i_dm_wvalid  input  1  store strobe, sampled on rising clk
- i_dm_wdata  input  XLEN  store data
- o_dm_rdata  output  XLEN  load data, combinational; 0 when address misses window
- o_hit  output  1  combinational, 1 when i_dm_addr[XLEN-1:4]==BASE_ADDR[XLEN-1:4]
- o_tx  output  1  serial line, registered, idle high
- o_irq  output  1  combinational level interrupt

Behaviour:
- One clock domain: clk. Reset: rstn, asynchronous assert, active-low.
- Register map (offset = addr[3:2]; addr[1:0] ignored):
  - 0 TXDATA, W: push wdata[7:0]; reads 0.
  - 1 STATUS, R: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, rest 0. W: writing 1 to bit3 clears overflow.
  - 2 CTRL, R/W: bit0 tx_en, bit1 irq_en; other bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Writes take effect only when o_hit & i_dm_wvalid at the rising edge.
- Reset state: FIFO empty (count 0), FSM IDLE, o_tx=1, overflow=0, tx_en=0, irq_en=0, o_irq=0.
  - o_dm_rdata is purely address-dependent: STATUS reads 0x0000_0002.
- FIFO:
  - Push is accepted when !full, or when full and the FSM pops in the same cycle; count is unchanged in that case.
  - Push when full with no pop: byte dropped, overflow set, FIFO unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[15:8].
- Serializer FSM: IDLE, START, DATA, STOP.
  - Bit-period counter 0..CLKS_PER_BIT-1; bit index 0..7.
  - IDLE: o_tx=1. If tx_en & !empty: pop head into the shift register, go to START. The pop occurs at the first edge after the push edge, so o_tx falls 1 cycle after the write is captured.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: o_tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. At its final cycle, if tx_en & !empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Clearing tx_en mid-frame: the current frame completes; no further pops. Setting tx_en with data already queued starts a frame next cycle.
- Reset mid-frame: o_tx=1 immediately (asynchronous); FIFO contents lost.
- Interrupt: o_irq = irq_en & empty & !busy.
- The bus may write TXDATA and the FSM may pop in the same cycle with the FIFO at any fill level; order of bytes must be preserved.

Test Plan:
- CLKS_PER_BIT=4, write CTRL=0x1, then TXDATA=0xA5 → o_tx low 1 cycle after the write for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy=1 for 40 cycles; STATUS returns 0x0000_0002 after.
- tx_en=0, write 9 bytes 0x01..0x09 with FIFO_DEPTH=8 → STATUS=0x0000_0809 (count 8, full, overflow). Write STATUS=0x8 → overflow clears. Set tx_en → frames 0x01..0x08 back-to-back, total 320 cycles, no gap; 0x09 never sent.
- FIFO full and FSM finishing STOP, write 0x55 in the pop cycle → accepted, count stays 8, overflow stays 0, 0x55 transmitted last.
- Clear tx_en mid-DATA of first of two queued bytes → first frame completes fully, o_tx stays 1, count=1; re-enable → second frame starts next cycle.
- irq_en=1, single byte sent → o_irq=0 while busy; rises on the cycle FSM returns to IDLE. Reads at BASE_ADDR+0x20 → o_hit=0, rdata=0.
- Assert rstn low during DATA bit 3 → o_tx=1 asynchronously. After release: STATUS=0x2, CTRL=0, no residual frame.
